spi_command_decoder: RTL
========================

Name: spi_command_decoder

Overview:
- Sits directly downstream of the 16-bit SPI slave in the FIR datapath.
- Consumes received SPI packets and decodes a header word per frame.
- Writes FIR coefficients, streams input samples to the filter, and returns filtered results through a small result FIFO.
- Drives the slave's transmit word so the host reads status and results in the same full-duplex frames.

Parameters:
- DATA_WIDTH, 16, SPI packet / sample / coefficient width.
- COEF_ADDR_WIDTH, 6, coefficient RAM address width (64 taps).
- RESULT_FIFO_DEPTH, 4, result FIFO entries; power of two, minimum 2.

Ports:
- clkIn  input  1  system clock.
- nResetIn  input  1  asynchronous active-low reset.
- packetIn  input  DATA_WIDTH  received word from the SPI slave.
- packetValidIn  input  1  one-cycle pulse; packetIn is valid.
- txEmptyIn  input  1  one-cycle pulse; slave needs the next transmit word.
- busyIn  input  1  high while chip-select is asserted (frame active).
- txDataOut  output  DATA_WIDTH  transmit word presented to the SPI slave.
- coefWrOut  output  1  coefficient write strobe.
- coefAddrOut  output  COEF_ADDR_WIDTH  coefficient write address.
- coefDataOut  output  DATA_WIDTH  coefficient write data.
- sampleValidOut  output  1  one-cycle pulse; sampleOut is valid for the FIR.
- sampleOut  output  DATA_WIDTH  input sample to the FIR.
- resultValidIn  input  1  filtered result valid; push into the FIFO.
- resultIn  input  DATA_WIDTH  filtered result.

Behaviour:
- Clocking and reset:
  - One clock, clkIn. nResetIn is asynchronous active-low.
  - On reset, all outputs are 0, the FIFO is empty, sticky flags are clear, and the FSM is in IDLE.
- Header word:
  - [15:12] opcode. [11:6] reserved (ignored). [5:0] start address.
  - Opcodes: 0 = NOP, 1 = COEF, 2 = STREAM, 3 = FLUSH. All others are illegal.
- Status word: [15] FIFO overflow, [14] tx underflow, [13] illegal opcode, [12:8] 0, [7:0] FIFO count (zero-extended).
- FSM states: IDLE, HEADER, COEF, STREAM, DRAIN.
  - IDLE: txDataOut = live status word. On busyIn rising: clear sticky flags the next cycle, go to HEADER. The slave captures the status at chip-select fall.
  - HEADER: on txEmptyIn, txDataOut <= 0 (slot 1 is always 0). On packetValidIn, decode:
    - COEF: load addr.
    - STREAM: go to STREAM.
    - FLUSH: empty the FIFO next cycle, go to DRAIN.
    - NOP: go to DRAIN.
    - Illegal: set the illegal flag, go to DRAIN.
  - COEF: each packetValidIn at cycle t produces coefWrOut = 1 at t+1, with coefAddrOut = addr and coefDataOut = packetIn. addr then increments and wraps 63 -> 0. Transmit slots are 0.
  - STREAM:
    - Each packetValidIn at t produces sampleValidOut = 1 at t+1 with sampleOut = packetIn.
    - Each txEmptyIn at t: if the FIFO is non-empty, pop into txDataOut at t+1. Otherwise txDataOut <= 0 and set the underflow flag.
  - DRAIN: ignore packets; txDataOut <= 0 on each txEmptyIn.
  - Any state: busyIn low returns to IDLE the next cycle. A partial word produces no write or sample.
- Result FIFO:
  - Pushes on resultValidIn in any state.
  - Push when full: drop the word, set the overflow flag.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push and pop in the same cycle when empty: the pop yields 0 and sets underflow; the push is stored.
  - FLUSH and push in the same cycle: flush wins; the FIFO ends empty.
- Simultaneous packetValidIn and txEmptyIn: both are handled in the same cycle; no priority needed.
- Sticky flags are set-dominant over clear when both occur in the same cycle.

Optional Feature:
- Macro: SPI_CMD_LOOPBACK_EN.
- Defined: opcode 4 = LOOPBACK. The data word received in slot k (k >= 1) is returned in tx slot k+2 through a one-word hold register. Slots 1 and 2 are 0. No samples or coefficient writes are generated.
- Not defined: opcode 4 is illegal, handled like any other illegal opcode.

Test Plan:
- Coefficient write: frame {0x1005, 0xAAAA, 0xBBBB} -> coefWrOut pulses at addr 5 = 0xAAAA and addr 6 = 0xBBBB, one cycle after each packetValidIn. Coefficient wrap: frame {0x103F, 0x1111, 0x2222} -> writes addr 63 = 0x1111, then addr 0 = 0x2222.
- Stream: push results 0x0101 and 0x0202, then frame {0x2000, 0x0010, 0x0020, 0x0030} -> sampleOut 0x0010, 0x0020, 0x0030. Tx slots read 0x0002 (status, count = 2), 0x0000, 0x0101, 0x0202. No underflow.
- Overflow and status: push 5 results with depth 4 -> next frame's slot 0 = 0x8004. After that frame, the overflow flag is clear and the following frame's slot 0 reflects only new events.
- Illegal opcode and underflow: frame {0x7000} -> next slot 0 has bit 13 set. Stream frame with an empty FIFO and 3 words -> slot 2 = 0 and the next status has bit 14 set.
- Abort and reset: deassert busyIn mid-word in COEF -> no coefWrOut; the next frame starts in HEADER. Assert nResetIn mid-STREAM -> all outputs are 0 immediately, the FIFO count is 0, and status = 0x0000.
- Flush: 3 results queued, frame {0x3000} -> the next frame's slot 0 = 0x0000.

Source files
------------

// File: rtl/spi_command_decoder.sv
`default_nettype none
// ============================================================================
// Module   : spi_command_decoder
// Purpose  : Frame decoder behind the 16-bit SPI slave: coefficient writes,
//            FIR sample streaming and result read-back via a small FIFO.
// Options  : SPI_CMD_LOOPBACK_EN enables opcode 4 (data echoed two slots later)
// Revision : 1.0 - initial release
// ============================================================================
module spi_command_decoder #(
    parameter int DATA_WIDTH        = 16,
    parameter int COEF_ADDR_WIDTH   = 6,
    parameter int RESULT_FIFO_DEPTH = 4
) (
    input  logic                       clkIn,
    input  logic                       nResetIn,
    input  logic [DATA_WIDTH-1:0]      packetIn,
    input  logic                       packetValidIn,
    input  logic                       txEmptyIn,
    input  logic                       busyIn,
    output logic [DATA_WIDTH-1:0]      txDataOut,
    output logic                       coefWrOut,
    output logic [COEF_ADDR_WIDTH-1:0] coefAddrOut,
    output logic [DATA_WIDTH-1:0]      coefDataOut,
    output logic                       sampleValidOut,
    output logic [DATA_WIDTH-1:0]      sampleOut,
    input  logic                       resultValidIn,
    input  logic [DATA_WIDTH-1:0]      resultIn
);

    localparam int PTR_W = (RESULT_FIFO_DEPTH > 1) ? $clog2(RESULT_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_FIFO_FULL = CNT_W'(RESULT_FIFO_DEPTH);

    localparam logic [3:0] c_OP_NOP    = 4'd0;
    localparam logic [3:0] c_OP_COEF   = 4'd1;
    localparam logic [3:0] c_OP_STREAM = 4'd2;
    localparam logic [3:0] c_OP_FLUSH  = 4'd3;
`ifdef SPI_CMD_LOOPBACK_EN
    localparam logic [3:0] c_OP_LOOP   = 4'd4;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_COEF   = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_LOOP   = 3'd5
    } state_t;

    state_t                     r_state_q, w_state_d;
    logic [DATA_WIDTH-1:0]      r_tx_q, w_tx_d;
    logic [COEF_ADDR_WIDTH-1:0] r_addr_q, w_addr_d;
    logic                       r_coef_wr_q, w_coef_wr_d;
    logic [COEF_ADDR_WIDTH-1:0] r_coef_addr_q, w_coef_addr_d;
    logic [DATA_WIDTH-1:0]      r_coef_data_q, w_coef_data_d;
    logic                       r_sample_valid_q, w_sample_valid_d;
    logic [DATA_WIDTH-1:0]      r_sample_q, w_sample_d;
    logic                       r_ovf_q, w_ovf_d;
    logic                       r_unf_q, w_unf_d;
    logic                       r_ill_q, w_ill_d;
`ifdef SPI_CMD_LOOPBACK_EN
    logic [DATA_WIDTH-1:0]      r_hold_q, w_hold_d;
`endif

    logic [DATA_WIDTH-1:0]      r_mem_q [RESULT_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]      w_mem_d [RESULT_FIFO_DEPTH];
    logic [PTR_W-1:0]           r_wr_ptr_q, w_wr_ptr_d;
    logic [PTR_W-1:0]           r_rd_ptr_q, w_rd_ptr_d;
    logic [CNT_W-1:0]           r_count_q, w_count_d;

    logic                       w_pop, w_pop_ok, w_push_ok, w_flush, w_clear;
    logic                       w_set_ovf, w_set_unf, w_set_ill;
    logic                       w_fifo_full, w_fifo_empty;
    logic [3:0]                 w_opcode;
    logic [7:0]                 w_count8;
    logic [DATA_WIDTH-1:0]      w_status;

    assign w_opcode     = packetIn[DATA_WIDTH-1 -: 4];
    assign w_fifo_full  = (r_count_q == c_FIFO_FULL);
    assign w_fifo_empty = (r_count_q == '0);
    assign w_count8     = {{(8-CNT_W){1'b0}}, r_count_q};
    assign w_status     = {r_ovf_q, r_unf_q, r_ill_q, {(DATA_WIDTH-11){1'b0}}, w_count8};

    // Frame sequencing; busyIn low always wins and abandons the frame.
    always_comb begin
        w_state_d        = r_state_q;
        w_tx_d           = r_tx_q;
        w_addr_d         = r_addr_q;
        w_coef_wr_d      = 1'b0;
        w_coef_addr_d    = r_coef_addr_q;
        w_coef_data_d    = r_coef_data_q;
        w_sample_valid_d = 1'b0;
        w_sample_d       = r_sample_q;
        w_pop            = 1'b0;
        w_flush          = 1'b0;
        w_clear          = 1'b0;
        w_set_unf        = 1'b0;
        w_set_ill        = 1'b0;
`ifdef SPI_CMD_LOOPBACK_EN
        w_hold_d         = r_hold_q;
`endif
        if (!busyIn) begin
            w_state_d = S_IDLE;
        end else begin
            case (r_state_q)
                S_IDLE: begin
                    w_state_d = S_HEADER;
                    w_clear   = 1'b1;
                    w_tx_d    = '0;
                end
                S_HEADER: begin
                    if (txEmptyIn) w_tx_d = '0;
                    if (packetValidIn) begin
                        case (w_opcode)
                            c_OP_NOP:    w_state_d = S_DRAIN;
                            c_OP_COEF: begin
                                w_addr_d  = packetIn[COEF_ADDR_WIDTH-1:0];
                                w_state_d = S_COEF;
                            end
                            c_OP_STREAM: w_state_d = S_STREAM;
                            c_OP_FLUSH: begin
                                w_flush   = 1'b1;
                                w_state_d = S_DRAIN;
                            end
`ifdef SPI_CMD_LOOPBACK_EN
                            c_OP_LOOP: begin
                                w_hold_d  = '0;
                                w_state_d = S_LOOP;
                            end
`endif
                            default: begin
                                w_set_ill = 1'b1;
                                w_state_d = S_DRAIN;
                            end
                        endcase
                    end
                end
                S_COEF: begin
                    if (txEmptyIn) w_tx_d = '0;
                    if (packetValidIn) begin
                        w_coef_wr_d   = 1'b1;
                        w_coef_addr_d = r_addr_q;
                        w_coef_data_d = packetIn;
                        w_addr_d      = r_addr_q + 1'b1;
                    end
                end
                S_STREAM: begin
                    if (packetValidIn) begin
                        w_sample_valid_d = 1'b1;
                        w_sample_d       = packetIn;
                    end
                    if (txEmptyIn) begin
                        w_pop = 1'b1;
                        if (!w_fifo_empty) begin
                            w_tx_d = r_mem_q[r_rd_ptr_q];
                        end else begin
                            w_tx_d    = '0;
                            w_set_unf = 1'b1;
                        end
                    end
                end
`ifdef SPI_CMD_LOOPBACK_EN
                S_LOOP: begin
                    // tx reads the hold register before this cycle's packet lands in it
                    if (txEmptyIn)     w_tx_d   = r_hold_q;
                    if (packetValidIn) w_hold_d = packetIn;
                end
`endif
                S_DRAIN: begin
                    if (txEmptyIn) w_tx_d = '0;
                end
                default: w_state_d = S_IDLE;
            endcase
        end
    end

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign w_pop_ok  = w_pop && !w_fifo_empty;
    assign w_push_ok = resultValidIn && (!w_fifo_full || w_pop_ok) && !w_flush;
    assign w_set_ovf = resultValidIn && !w_push_ok && !w_flush;

    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (w_push_ok) begin
                w_mem_d[r_wr_ptr_q] = resultIn;
                w_wr_ptr_d          = r_wr_ptr_q + 1'b1;
            end
            if (w_pop_ok) w_rd_ptr_d = r_rd_ptr_q + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   w_count_d = r_count_q + 1'b1;
                2'b01:   w_count_d = r_count_q - 1'b1;
                default: w_count_d = r_count_q;
            endcase
        end
    end

    assign w_ovf_d = w_set_ovf | (r_ovf_q & ~w_clear);
    assign w_unf_d = w_set_unf | (r_unf_q & ~w_clear);
    assign w_ill_d = w_set_ill | (r_ill_q & ~w_clear);

    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            r_state_q        <= S_IDLE;
            r_tx_q           <= '0;
            r_addr_q         <= '0;
            r_coef_wr_q      <= 1'b0;
            r_coef_addr_q    <= '0;
            r_coef_data_q    <= '0;
            r_sample_valid_q <= 1'b0;
            r_sample_q       <= '0;
            r_ovf_q          <= 1'b0;
            r_unf_q          <= 1'b0;
            r_ill_q          <= 1'b0;
            r_mem_q          <= '{default: '0};
            r_wr_ptr_q       <= '0;
            r_rd_ptr_q       <= '0;
            r_count_q        <= '0;
`ifdef SPI_CMD_LOOPBACK_EN
            r_hold_q         <= '0;
`endif
        end else begin
            r_state_q        <= w_state_d;
            r_tx_q           <= w_tx_d;
            r_addr_q         <= w_addr_d;
            r_coef_wr_q      <= w_coef_wr_d;
            r_coef_addr_q    <= w_coef_addr_d;
            r_coef_data_q    <= w_coef_data_d;
            r_sample_valid_q <= w_sample_valid_d;
            r_sample_q       <= w_sample_d;
            r_ovf_q          <= w_ovf_d;
            r_unf_q          <= w_unf_d;
            r_ill_q          <= w_ill_d;
            r_mem_q          <= w_mem_d;
            r_wr_ptr_q       <= w_wr_ptr_d;
            r_rd_ptr_q       <= w_rd_ptr_d;
            r_count_q        <= w_count_d;
`ifdef SPI_CMD_LOOPBACK_EN
            r_hold_q         <= w_hold_d;
`endif
        end
    end

    // Status is live while idle so the slave latches current flags at chip-select fall.
    assign txDataOut      = (r_state_q == S_IDLE) ? w_status : r_tx_q;
    assign coefWrOut      = r_coef_wr_q;
    assign coefAddrOut    = r_coef_addr_q;
    assign coefDataOut    = r_coef_data_q;
    assign sampleValidOut = r_sample_valid_q;
    assign sampleOut      = r_sample_q;

endmodule
`default_nettype wire
